sdram_core_arbiter: RTL and testbench

//  Shares one sdram_core_if subordinate (the SDRAM controller) between NUM_REQ managers.

---
 rtl/sdram_arb_pkg.sv | 39 +++
 rtl/sdram_core_arbiter_id_fifo.sv | 51 +++++
 rtl/sdram_core_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_core_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and round-robin helpers for the SDRAM core arbiter.
// req_id_t is sized from ARB_NUM_REQ, so the arbiter's NUM_REQ must match it.
package sdram_arb_pkg;

    localparam int ARB_NUM_REQ = 2;
    localparam int ARB_ID_W    = (ARB_NUM_REQ > 1) ? $clog2(ARB_NUM_REQ) : 1;

    typedef logic [ARB_ID_W-1:0] req_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // First requester found searching upward from ptr, wrapping at ARB_NUM_REQ.
    function automatic req_id_t rr_pick(input logic [ARB_NUM_REQ-1:0] req_vec,
                                        input req_id_t                ptr);
        req_id_t                pick;
        logic                   found;
        int                     idx;
        logic [ARB_NUM_REQ-1:0] rot;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < ARB_NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % ARB_NUM_REQ;
            rot = req_vec >> idx;
            if (!found && rot[0]) begin
                pick  = req_id_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic req_id_t rr_next(input req_id_t id);
        return (int'(id) == ARB_NUM_REQ - 1) ? '0 : id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/sdram_core_arbiter_id_fifo.sv
// In-order record of which manager owns each accepted-but-unanswered request.
// The arbiter never pushes when full nor pops when empty.
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  req_id_t       i_push_id,
    input  logic          i_pop,
    output req_id_t       o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    req_id_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sdram_core_arbiter.sv
// Round-robin arbiter sharing one SDRAM core between NUM_REQ managers,
// with an ID FIFO routing in-order responses back to their issuers.
module sdram_core_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int WORD_LEN        = DATA_WIDTH / 8,
    parameter  int NUM_REQ         = ARB_NUM_REQ,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ*WORD_LEN-1:0]    req_wr,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_write_data,
    output logic [NUM_REQ-1:0]             req_accept,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_error,
    output logic [DATA_WIDTH-1:0]          req_read_data,
    output logic [WORD_LEN-1:0]            core_wr,
    output logic                           core_rd,
    output logic [ADDR_WIDTH-1:0]          core_addr,
    output logic [DATA_WIDTH-1:0]          core_write_data,
    input  logic                           core_accept,
    input  logic                           core_ack,
    input  logic                           core_error,
    input  logic [DATA_WIDTH-1:0]          core_read_data,
    output logic                           spurious_rsp,
    output arb_state_e                     dbg_state,
    output logic [CW-1:0]                  dbg_count
);

    arb_state_e            r_state, w_state_nxt;
    req_id_t               r_lock_id, w_lock_id_nxt;
    req_id_t               r_rr_ptr, w_rr_ptr_nxt;
    logic                  r_spurious;

    logic [NUM_REQ-1:0]    w_req_vec;
    req_id_t               w_pick, w_drive_id, w_head;
    logic                  w_active, w_issue, w_accept, w_rsp, w_pop;
    logic                  w_full, w_empty;
    logic [CW-1:0]         w_count;
    logic [WORD_LEN-1:0]   w_sel_wr;
    logic                  w_sel_rd;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    always_comb begin
        w_req_vec = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_req_vec[i] = (|req_wr[i*WORD_LEN +: WORD_LEN]) | req_rd[i];
    end

    // A lock freezes arbitration; otherwise the winner drives the core this same cycle.
    assign w_pick     = rr_pick(w_req_vec, r_rr_ptr);
    assign w_drive_id = (r_state == LOCKED) ? r_lock_id : w_pick;
    assign w_active   = rst_n && ((r_state == LOCKED) || (|w_req_vec));
    assign w_issue    = w_active && !w_full;
    assign w_accept   = core_accept && w_issue;

    always_comb begin
        w_sel_wr   = '0;
        w_sel_rd   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_id_t'(i) == w_drive_id) begin
                w_sel_wr   = req_wr[i*WORD_LEN +: WORD_LEN];
                w_sel_rd   = req_rd[i];
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign core_wr         = w_issue  ? w_sel_wr   : '0;
    assign core_rd         = w_issue  ? w_sel_rd   : 1'b0;
    assign core_addr       = w_active ? w_sel_addr : '0;
    assign core_write_data = w_active ? w_sel_data : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        w_rr_ptr_nxt  = r_rr_ptr;
        req_accept    = '0;
        if (w_accept) begin
            req_accept[w_drive_id] = 1'b1;
            w_state_nxt            = IDLE;
            w_rr_ptr_nxt           = rr_next(w_drive_id);
        end else if (w_issue) begin
            w_state_nxt   = LOCKED;
            w_lock_id_nxt = w_drive_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lock_id  <= '0;
            r_rr_ptr   <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            if (w_rsp && w_empty) r_spurious <= 1'b1;
        end
    end

    // Responses come back in issue order, so the FIFO head names the owner.
    assign w_rsp = core_ack | core_error;
    assign w_pop = w_rsp && !w_empty;

    always_comb begin
        req_ack   = '0;
        req_error = '0;
        if (w_pop) begin
            req_ack[w_head]   = core_ack;
            req_error[w_head] = core_error;
        end
    end

    sdram_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_push_id (w_drive_id),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign req_read_data = core_read_data;
    assign spurious_rsp  = r_spurious;
    assign dbg_state     = r_state;
    assign dbg_count     = w_count;

endmodule

// File: tb/tb_sdram_core_arbiter.sv
// Directed bench for sdram_core_arbiter: locking, round-robin, issue gate,
// response routing, spurious responses and mid-lock reset.
module tb_sdram_core_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = 4;
    localparam int NR = 2;
    localparam int MO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*WL-1:0] req_wr;
    logic [NR-1:0]    req_rd;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_write_data;
    logic [NR-1:0]    req_accept, req_ack, req_error;
    logic [DW-1:0]    req_read_data;
    logic [WL-1:0]    core_wr;
    logic             core_rd;
    logic [AW-1:0]    core_addr;
    logic [DW-1:0]    core_write_data;
    logic             core_accept, core_ack, core_error;
    logic [DW-1:0]    core_read_data;
    logic             spurious_rsp;
    arb_state_e       dbg_state;
    logic [2:0]       dbg_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_grant0 = 0;
    int n_grant1 = 0;

    always #5 clk = ~clk;

    sdram_core_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL),
        .NUM_REQ(NR), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr),
        .req_write_data(req_write_data),
        .req_accept(req_accept), .req_ack(req_ack), .req_error(req_error),
        .req_read_data(req_read_data),
        .core_wr(core_wr), .core_rd(core_rd), .core_addr(core_addr),
        .core_write_data(core_write_data),
        .core_accept(core_accept), .core_ack(core_ack), .core_error(core_error),
        .core_read_data(core_read_data),
        .spurious_rsp(spurious_rsp),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int m, input logic [WL-1:0] wr, input logic rd,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_wr[m*WL +: WL]         = wr;
        req_rd[m]                  = rd;
        req_addr[m*AW +: AW]       = addr;
        req_write_data[m*DW +: DW] = data;
    endtask

    initial begin
        rst_n = 1'b0;
        req_wr = '0; req_rd = '0; req_addr = '0; req_write_data = '0;
        core_accept = 1'b0; core_ack = 1'b0; core_error = 1'b0; core_read_data = '0;
        #2;
        chk("rst_core_rd",  64'(core_rd),      64'h0);
        chk("rst_core_wr",  64'(core_wr),      64'h0);
        chk("rst_accept",   64'(req_accept),   64'h0);
        chk("rst_ack",      64'(req_ack),      64'h0);
        chk("rst_spurious", 64'(spurious_rsp), 64'h0);
        chk("rst_state",    64'(dbg_state),    64'h0);
        tick; tick;
        rst_n = 1'b1;

        // 1) single manager read, accept after 3 cycles, ack 5 cycles later
        tick; set_req(0, 4'h0, 1'b1, 32'h100, 32'h0); settle;
        chk("t1_core_rd",   64'(core_rd),    64'h1);
        chk("t1_core_addr", 64'(core_addr),  64'h100);
        chk("t1_no_accept", 64'(req_accept), 64'h0);
        tick; settle;
        chk("t1_locked",    64'(dbg_state),  64'h1);
        chk("t1_hold_rd",   64'(core_rd),    64'h1);
        tick; settle;
        chk("t1_hold_addr", 64'(core_addr),  64'h100);
        tick; core_accept = 1'b1; settle;
        chk("t1_accept",    64'(req_accept), 64'h1);
        tick; set_req(0, 4'h0, 1'b0, 32'h0, 32'h0); core_accept = 1'b0; settle;
        chk("t1_idle_rd",   64'(core_rd),    64'h0);
        chk("t1_idle",      64'(dbg_state),  64'h0);
        chk("t1_count1",    64'(dbg_count),  64'h1);
        repeat (4) tick;
        core_ack = 1'b1; core_read_data = 32'hDEADBEEF; settle;
        chk("t1_ack",       64'(req_ack),       64'h1);
        chk("t1_rdata",     64'(req_read_data), 64'hDEADBEEF);
        tick; core_ack = 1'b0; core_read_data = 32'h0; settle;
        chk("t1_ack_off",   64'(req_ack),   64'h0);
        chk("t1_count0",    64'(dbg_count), 64'h0);

        // 2) both managers always requesting, immediate accept: strict alternation
        tick;
        set_req(0, 4'h0, 1'b1, 32'h1000, 32'h0);
        set_req(1, 4'h0, 1'b1, 32'h2000, 32'h0);
        core_accept = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                tick;
                core_ack = 1'b1;
            end
            settle;
            chk("t2_grant", 64'(req_accept), (k % 2 == 0) ? 64'h2 : 64'h1);
            if (k > 0) chk("t2_route", 64'(req_ack), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (req_accept == 2'b01) n_grant0++;
            if (req_accept == 2'b10) n_grant1++;
        end
        chk("t2_grants_m0", 64'(n_grant0), 64'd50);
        chk("t2_grants_m1", 64'(n_grant1), 64'd50);
        tick;
        set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
        set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
        core_accept = 1'b0; settle;
        chk("t2_drain_ack", 64'(req_ack), 64'h1);
        chk("t2_drain_rd",  64'(core_rd), 64'h0);
        tick; core_ack = 1'b0; settle;
        chk("t2_count0",    64'(dbg_count), 64'h0);

        // 3) manager 1 locked for 4 cycles while manager 0 waits
        tick; set_req(1, 4'hF, 1'b0, 32'h200, 32'h11112222); settle;
        chk("t3_wr",   64'(core_wr),   64'hF);
        chk("t3_addr", 64'(core_addr), 64'h200);
        tick; set_req(0, 4'h0, 1'b1, 32'h300, 32'h0); settle;
        for (int k = 0; k < 3; k++) begin
            chk("t3_lock_addr", 64'(core_addr),       64'h200);
            chk("t3_lock_data", 64'(core_write_data), 64'h11112222);
            chk("t3_lock_rd",   64'(core_rd),         64'h0);
            tick; settle;
        end
        core_accept = 1'b1; settle;
        chk("t3_acc_m1",  64'(req_accept), 64'h2);
        tick; set_req(1, 4'h0, 1'b0, 32'h0, 32'h0); settle;
        chk("t3_m0_rd",   64'(core_rd),    64'h1);
        chk("t3_m0_addr", 64'(core_addr),  64'h300);
        chk("t3_acc_m0",  64'(req_accept), 64'h1);
        tick; set_req(0, 4'h0, 1'b0, 32'h0, 32'h0); core_accept = 1'b0; core_ack = 1'b1; settle;
        chk("t3_ack_m1",  64'(req_ack), 64'h2);
        tick; settle;
        chk("t3_ack_m0",  64'(req_ack), 64'h1);
        tick; core_ack = 1'b0; settle;
        chk("t3_count0",  64'(dbg_count), 64'h0);

        // 4) four writes fill the outstanding budget; the fifth waits for an ack
        tick; core_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick;
            set_req(0, 4'hF, 1'b0, 32'h4000 + 32'(k * 4), 32'hA0 + 32'(k));
            settle;
            chk("t4_fill_acc", 64'(req_accept), 64'h1);
        end
        tick; set_req(0, 4'h3, 1'b0, 32'h4010, 32'hA4); settle;
        chk("t4_gate_wr",   64'(core_wr),    64'h0);
        chk("t4_gate_acc",  64'(req_accept), 64'h0);
        chk("t4_full",      64'(dbg_count),  64'h4);
        tick; core_ack = 1'b1; settle;
        chk("t4_ack_wr",    64'(core_wr),    64'h0);
        chk("t4_ack_acc",   64'(req_accept), 64'h0);
        chk("t4_ack",       64'(req_ack),    64'h1);
        tick; core_ack = 1'b0; settle;
        chk("t4_reopen_wr", 64'(core_wr),    64'h3);
        chk("t4_reopen_acc",64'(req_accept), 64'h1);
        chk("t4_count3",    64'(dbg_count),  64'h3);
        tick; set_req(0, 4'h0, 1'b0, 32'h0, 32'h0); core_accept = 1'b0; core_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick;
            settle;
            chk("t4_drain_ack", 64'(req_ack), 64'h1);
        end
        tick; core_ack = 1'b0; settle;
        chk("t4_count0",    64'(dbg_count), 64'h0);

        // 5) accepts 1,0,1 interleaved with acks, one ack coinciding with an accept
        tick; set_req(1, 4'h0, 1'b1, 32'h500, 32'h0); core_accept = 1'b1; settle;
        chk("t5_acc_a", 64'(req_accept), 64'h2);
        tick; set_req(1, 4'h0, 1'b0, 32'h0, 32'h0); set_req(0, 4'h0, 1'b1, 32'h600, 32'h0); settle;
        chk("t5_acc_b", 64'(req_accept), 64'h1);
        tick; set_req(0, 4'h0, 1'b0, 32'h0, 32'h0); set_req(1, 4'h0, 1'b1, 32'h700, 32'h0);
        core_accept = 1'b0; settle;
        chk("t5_wait",  64'(req_accept), 64'h0);
        chk("t5_addr",  64'(core_addr),  64'h700);
        tick; core_ack = 1'b1; settle;
        chk("t5_ack_a", 64'(req_ack),    64'h2);
        chk("t5_lockd", 64'(dbg_state),  64'h1);
        tick; core_accept = 1'b1; settle;
        chk("t5_acc_c", 64'(req_accept), 64'h2);
        chk("t5_ack_b", 64'(req_ack),    64'h1);
        tick; set_req(1, 4'h0, 1'b0, 32'h0, 32'h0); core_accept = 1'b0; core_ack = 1'b0; settle;
        chk("t5_quiet", 64'(req_ack),    64'h0);
        chk("t5_count", 64'(dbg_count),  64'h1);
        tick; core_error = 1'b1; settle;
        chk("t5_err_c", 64'(req_error),  64'h2);
        chk("t5_noack", 64'(req_ack),    64'h0);
        tick; core_error = 1'b0; settle;
        chk("t5_count0",64'(dbg_count),  64'h0);

        // 6) spurious response, then reset mid-lock with two outstanding
        tick; core_ack = 1'b1; settle;
        chk("t6_spur_noack", 64'(req_ack), 64'h0);
        tick; core_ack = 1'b0; settle;
        chk("t6_spur_set",   64'(spurious_rsp), 64'h1);
        tick; settle;
        chk("t6_spur_stick", 64'(spurious_rsp), 64'h1);
        tick; set_req(0, 4'hF, 1'b0, 32'h800, 32'h1); core_accept = 1'b1; settle;
        chk("t6_acc_a", 64'(req_accept), 64'h1);
        tick; set_req(0, 4'hF, 1'b0, 32'h804, 32'h2); settle;
        chk("t6_acc_b", 64'(req_accept), 64'h1);
        tick; set_req(0, 4'h0, 1'b0, 32'h0, 32'h0); set_req(1, 4'h0, 1'b1, 32'h900, 32'h0);
        core_accept = 1'b0; settle;
        chk("t6_rd",    64'(core_rd), 64'h1);
        tick; settle;
        chk("t6_locked", 64'(dbg_state), 64'h1);
        chk("t6_out2",   64'(dbg_count), 64'h2);
        #1; rst_n = 1'b0; #1;
        chk("t6_rst_rd",    64'(core_rd),      64'h0);
        chk("t6_rst_addr",  64'(core_addr),    64'h0);
        chk("t6_rst_acc",   64'(req_accept),   64'h0);
        chk("t6_rst_state", 64'(dbg_state),    64'h0);
        chk("t6_rst_count", 64'(dbg_count),    64'h0);
        chk("t6_rst_spur",  64'(spurious_rsp), 64'h0);
        tick; set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
        tick; rst_n = 1'b1;
        tick; core_ack = 1'b1; settle;
        chk("t6_post_noack", 64'(req_ack), 64'h0);
        tick; core_ack = 1'b0; settle;
        chk("t6_post_spur",  64'(spurious_rsp), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
